nn_argmax_classifier: RTL and testbench

Output stage directly downstream of the MLP forward pass. It captures the 10 Q8.8 output-layer logits when the forward pass signals completion. It then scans them sequentially, one per cycle, to find the winning class, the top score and the top1-top2 confidence margin. The result is presented on a valid/ready handshake to the system controller or readout logic.

---
 rtl/nn_argmax_classifier.sv | 135 +++++++++++++
 tb/tb_nn_argmax_classifier.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_argmax_classifier.sv
// Argmax stage after the MLP forward pass: captures the output logits on a
// completion edge, scans them one per cycle and hands off class/top1/margin.
module nn_argmax_classifier #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          nn_done,
    input  logic [NUM_CLASSES*DATA_W-1:0] logits,
    output logic                          class_valid,
    input  logic                          class_ready,
    output logic [IDX_W-1:0]              class_idx,
    output logic [DATA_W-1:0]             top1_val,
    output logic [DATA_W:0]               margin,
    output logic                          busy,
    output logic                          overrun,
    output logic [15:0]                   frame_cnt
);

    localparam logic [IDX_W-1:0]  LAST_K  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                   state;
    logic                     done_q;
    logic                     capture;
    logic [IDX_W-1:0]         k;
    logic signed [DATA_W-1:0] cap [NUM_CLASSES];
    logic signed [DATA_W-1:0] run_top1;
    logic signed [DATA_W-1:0] run_top2;
    logic [IDX_W-1:0]         run_idx;

    logic signed [DATA_W-1:0] cur;
    logic signed [DATA_W-1:0] nxt_top1;
    logic signed [DATA_W-1:0] nxt_top2;
    logic [IDX_W-1:0]         nxt_idx;
    logic signed [DATA_W:0]   nxt_margin;

    assign capture = nn_done & ~done_q;

    // Running top1/top2 update for the logit at scan position k
    always_comb begin
        cur      = cap[k];
        nxt_top1 = run_top1;
        nxt_top2 = run_top2;
        nxt_idx  = run_idx;
        if (k == '0) begin
            nxt_top1 = cur;
            nxt_top2 = MOST_NEG;
            nxt_idx  = '0;
        end else if (cur > run_top1) begin
            nxt_top2 = run_top1;
            nxt_top1 = cur;
            nxt_idx  = k;
        end else if (cur > run_top2) begin
            nxt_top2 = cur;
        end
        nxt_margin = {nxt_top1[DATA_W-1], nxt_top1} - {nxt_top2[DATA_W-1], nxt_top2};
    end

    // Logit snapshot; only the IDLE capture writes it so later frames are dropped
    always_ff @(posedge clk) begin
        if (state == IDLE && capture) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                cap[i] <= logits[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            k           <= '0;
            run_top1    <= '0;
            run_top2    <= '0;
            run_idx     <= '0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            top1_val    <= '0;
            margin      <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            done_q <= nn_done;
            if (capture && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (capture) begin
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    run_top1 <= nxt_top1;
                    run_top2 <= nxt_top2;
                    run_idx  <= nxt_idx;
                    if (k == LAST_K) begin
                        class_idx   <= nxt_idx;
                        top1_val    <= nxt_top1;
                        margin      <= nxt_margin;
                        class_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (class_valid && class_ready) begin
                        class_valid <= 1'b0;
                        frame_cnt   <= frame_cnt + 16'd1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Scoreboard bench for nn_argmax_classifier: stimulus pushes model results,
// a negedge monitor compares them whenever the DUT presents a result.
module tb_nn_argmax_classifier;

    localparam int unsigned NC     = 10;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 4;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] top1;
        logic [DATA_W:0]   margin;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     nn_done;
    logic [NC*DATA_W-1:0]     logits;
    logic                     class_valid;
    logic                     class_ready;
    logic [IDX_W-1:0]         class_idx;
    logic [DATA_W-1:0]        top1_val;
    logic [DATA_W:0]          margin;
    logic                     busy;
    logic                     overrun;
    logic [15:0]              frame_cnt;

    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;
    exp_t q[$];

    nn_argmax_classifier #(.NUM_CLASSES(NC), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .nn_done(nn_done), .logits(logits),
        .class_valid(class_valid), .class_ready(class_ready), .class_idx(class_idx),
        .top1_val(top1_val), .margin(margin), .busy(busy), .overrun(overrun),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: first index holding the maximum; top2 is the best of the rest
    function automatic exp_t model(input logic [DATA_W-1:0] v [NC]);
        exp_t r;
        int best = 0;
        int t1;
        int t2 = -32768;
        for (int i = 1; i < NC; i++) begin
            if ($signed(v[i]) > $signed(v[best])) best = i;
        end
        t1 = $signed(v[best]);
        for (int j = 0; j < NC; j++) begin
            if (j != best && $signed(v[j]) > t2) t2 = $signed(v[j]);
        end
        r.idx    = IDX_W'(best);
        r.top1   = DATA_W'(t1);
        r.margin = (DATA_W+1)'(t1 - t2);
        return r;
    endfunction

    task automatic set_logits(input logic [DATA_W-1:0] v [NC]);
        for (int i = 0; i < NC; i++) logits[i*DATA_W +: DATA_W] = v[i];
    endtask

    task automatic scramble_logits();
        for (int i = 0; i < NC; i++) logits[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] v [NC], input int hold,
                             input bit keep_done, input bit change, input bit pulse);
        int n;
        class_ready = 1'b0;
        nn_done     = 1'b0;
        @(posedge clk); #1;
        set_logits(v);
        q.push_back(model(v));
        nn_done = 1'b1;
        @(posedge clk); #1;
        if (!keep_done) nn_done = 1'b0;
        for (int i = 1; i <= NC; i++) begin
            @(posedge clk); #1;
            if (change) scramble_logits();
            chk("latency_valid", 32'(class_valid), 32'(i == NC));
        end
        chk("busy_hold", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 2) nn_done = 1'b1;
            if (pulse && h == 3) nn_done = 1'b0;
            @(posedge clk); #1;
        end
        class_ready = 1'b1;
        n = 0;
        while (class_valid && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        chk("handoff_timeout", 32'(class_valid), 32'd0);
        class_ready = 1'b0;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    endtask

    // Monitor: stability while pending, full compare and pop on handoff
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                exp_frames = 0;
            end else if (class_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(class_valid), 32'd0);
                end else begin
                    chk("class_idx", 32'(class_idx), 32'(q[0].idx));
                    chk("top1_val", 32'(top1_val), 32'(q[0].top1));
                    chk("margin", 32'(margin), 32'(q[0].margin));
                    if (class_ready) begin
                        chk("frame_cnt_pre", 32'(frame_cnt), 32'(exp_frames));
                        void'(q.pop_front());
                        exp_frames++;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] v [NC];
        rst_n       = 1'b0;
        nn_done     = 1'b0;
        class_ready = 1'b0;
        logits      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(class_valid), 32'd0);
        chk("rst_idx", 32'(class_idx), 32'd0);
        chk("rst_top1", 32'(top1_val), 32'd0);
        chk("rst_margin", 32'(margin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;

        v = '{16'h0100, 16'hFF00, 16'h0300, 16'h0280, 16'h0000,
              16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_frame(v, 0, 1'b0, 1'b0, 1'b0);
        v = '{16'h0000, 16'h0000, 16'h0000, 16'h0500, 16'h0000,
              16'h0000, 16'h0000, 16'h0500, 16'h0000, 16'h0000};
        run_frame(v, 1, 1'b0, 1'b0, 1'b0);
        v = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
              16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFE00};
        run_frame(v, 2, 1'b0, 1'b0, 1'b0);
        v = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF,
              16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_frame(v, 0, 1'b0, 1'b0, 1'b0);

        // Level-high completion with logits changing underneath the scan
        for (int i = 0; i < NC; i++) v[i] = DATA_W'($urandom);
        run_frame(v, 3, 1'b1, 1'b1, 1'b0);
        repeat (85) @(posedge clk);
        #1;
        chk("level_no_overrun", 32'(overrun), 32'd0);
        chk("level_single_busy", 32'(busy), 32'd0);
        chk("level_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        nn_done = 1'b0;

        // Random frames, some with forced ties at the maximum
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NC; i++) v[i] = DATA_W'($urandom);
            if (f % 3 == 0) v[$urandom_range(NC-1)] = v[$urandom_range(NC-1)];
            if (f % 5 == 1) for (int i = 0; i < NC; i++) v[i] = DATA_W'($urandom_range(3)) - 16'd1;
            run_frame(v, int'($urandom_range(4)), 1'b0, 1'b0, 1'b0);
        end

        // Backpressure with a dropped completion edge during HOLD
        for (int i = 0; i < NC; i++) v[i] = DATA_W'($urandom);
        run_frame(v, 20, 1'b0, 1'b0, 1'b1);
        chk("overrun_set", 32'(overrun), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("overrun_no_extra_frame", 32'(busy), 32'd0);

        // Reset while scanning position 5
        nn_done = 1'b0;
        @(posedge clk); #1;
        scramble_logits();
        nn_done = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        nn_done = 1'b0;
        @(posedge clk); #1;
        chk("midscan_valid", 32'(class_valid), 32'd0);
        chk("midscan_busy", 32'(busy), 32'd0);
        chk("midscan_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("midscan_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        v = '{16'h0010, 16'hFFF0, 16'h0020, 16'h0040, 16'h0030,
              16'h0040, 16'h8000, 16'h7000, 16'h0000, 16'h6FFF};
        run_frame(v, 2, 1'b0, 1'b0, 1'b0);
        chk("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
